// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, direct-mapped I-cache refilled one word at a
// time from the memory controller, and static-JAL / 2-bit BHT next-PC prediction.
module inst_fetch #(
  parameter int ICACHE_LINES = 16,
  parameter int BHT_SIZE     = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        stall,
  input  logic        rollback,
  input  logic [31:0] rollback_pc,
  input  logic        bp_update,
  input  logic [31:0] bp_pc,
  input  logic        bp_taken,
  output logic        mc_en,
  output logic [31:0] mc_addr,
  input  logic        mc_done,
  input  logic [31:0] mc_data,
  output logic        inst_rdy,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        jump_predict
);

  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = 28 - IDX_W;
  localparam int BHT_W = $clog2(BHT_SIZE);
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  typedef enum logic [0:0] {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t      state_r, state_nxt_s;
  logic [31:0] pc_r, pc_nxt_s;
  logic [1:0]  cnt_r, cnt_nxt_s;
  logic        mc_en_nxt_s;
  logic [31:0] mc_addr_nxt_s;
  logic        inst_rdy_nxt_s;
  logic [31:0] inst_nxt_s;
  logic [31:0] inst_pc_nxt_s;
  logic        jp_nxt_s;

  logic [31:0]       data_r [ICACHE_LINES-1:0][3:0];
  logic [TAG_W-1:0]  tag_r  [ICACHE_LINES-1:0];
  logic [ICACHE_LINES-1:0] valid_r;
  logic [1:0]        bht_r  [BHT_SIZE-1:0];

  logic [IDX_W-1:0] pc_idx_s, fill_idx_s;
  logic [TAG_W-1:0] pc_tag_s, fill_tag_s;
  logic [BHT_W-1:0] pc_bht_s, bp_idx_s;
  logic             hit_s, fill_we_s, fill_last_s;
  logic [31:0]      word_s, j_imm_s, b_imm_s;
  logic             unused_s;

  function automatic logic [1:0] bht_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
    return res;
  endfunction

  // The refill target comes from mc_addr so a rollback mid-refill cannot retarget it.
  assign pc_idx_s   = pc_r[4 +: IDX_W];
  assign pc_tag_s   = pc_r[31 -: TAG_W];
  assign fill_idx_s = mc_addr[4 +: IDX_W];
  assign fill_tag_s = mc_addr[31 -: TAG_W];
  assign pc_bht_s   = pc_r[BHT_W+1:2];
  assign bp_idx_s   = bp_pc[BHT_W+1:2];
  assign hit_s      = valid_r[pc_idx_s] && (tag_r[pc_idx_s] == pc_tag_s);
  assign word_s     = data_r[pc_idx_s][pc_r[3:2]];
  assign j_imm_s    = {{12{word_s[31]}}, word_s[19:12], word_s[20], word_s[30:21], 1'b0};
  assign b_imm_s    = {{20{word_s[31]}}, word_s[7], word_s[30:25], word_s[11:8], 1'b0};
  assign unused_s   = ^{bp_pc[31:BHT_W+2], bp_pc[1:0]};

  // Next-state, next-PC and output decode; everything holds while rdy is low.
  always_comb begin
    state_nxt_s    = state_r;
    pc_nxt_s       = pc_r;
    cnt_nxt_s      = cnt_r;
    mc_en_nxt_s    = mc_en;
    mc_addr_nxt_s  = mc_addr;
    inst_rdy_nxt_s = inst_rdy;
    inst_nxt_s     = inst;
    inst_pc_nxt_s  = inst_pc;
    jp_nxt_s       = jump_predict;
    fill_we_s      = 1'b0;
    fill_last_s    = 1'b0;
    if (rdy) begin
      inst_rdy_nxt_s = 1'b0;
      case (state_r)
        IDLE: begin
          if (rollback) begin
            pc_nxt_s = rollback_pc;
          end else if (hit_s) begin
            if (!stall) begin
              inst_rdy_nxt_s = 1'b1;
              inst_nxt_s     = word_s;
              inst_pc_nxt_s  = pc_r;
              if (word_s[6:0] == OP_JAL) begin
                pc_nxt_s = pc_r + j_imm_s;
                jp_nxt_s = 1'b1;
              end else if ((word_s[6:0] == OP_BR) && bht_r[pc_bht_s][1]) begin
                pc_nxt_s = pc_r + b_imm_s;
                jp_nxt_s = 1'b1;
              end else begin
                pc_nxt_s = pc_r + 32'd4;
                jp_nxt_s = 1'b0;
              end
            end else begin
              pc_nxt_s = pc_r;
            end
          end else begin
            state_nxt_s   = FETCH;
            cnt_nxt_s     = 2'd0;
            mc_en_nxt_s   = 1'b1;
            mc_addr_nxt_s = {pc_r[31:4], 4'b0000};
          end
        end
        FETCH: begin
          if (rollback) begin
            pc_nxt_s = rollback_pc;
          end else begin
            pc_nxt_s = pc_r;
          end
          if (mc_done) begin
            fill_we_s = 1'b1;
            if (cnt_r == 2'd3) begin
              fill_last_s = 1'b1;
              mc_en_nxt_s = 1'b0;
              cnt_nxt_s   = 2'd0;
              state_nxt_s = IDLE;
            end else begin
              cnt_nxt_s     = cnt_r + 2'd1;
              mc_addr_nxt_s = mc_addr + 32'd4;
              mc_en_nxt_s   = 1'b1;
            end
          end else begin
            mc_en_nxt_s = 1'b1;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      pc_r         <= 32'd0;
      cnt_r        <= 2'd0;
      mc_en        <= 1'b0;
      mc_addr      <= 32'd0;
      inst_rdy     <= 1'b0;
      inst         <= 32'd0;
      inst_pc      <= 32'd0;
      jump_predict <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      cnt_r        <= cnt_nxt_s;
      mc_en        <= mc_en_nxt_s;
      mc_addr      <= mc_addr_nxt_s;
      inst_rdy     <= inst_rdy_nxt_s;
      inst         <= inst_nxt_s;
      inst_pc      <= inst_pc_nxt_s;
      jump_predict <= jp_nxt_s;
    end
  end

  // Line data and tags; meaningless until the valid bit is set, so no reset.
  always_ff @(posedge clk) begin
    if (fill_we_s) begin
      data_r[fill_idx_s][cnt_r] <= mc_data;
    end
    if (fill_last_s) begin
      tag_r[fill_idx_s] <= fill_tag_s;
    end
  end

  // Valid bits and branch history counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_r <= '0;
      for (int i = 0; i < BHT_SIZE; i++) begin
        bht_r[i] <= 2'b01;
      end
    end else if (rdy) begin
      if (fill_last_s) begin
        valid_r[fill_idx_s] <= 1'b1;
      end
      if (bp_update) begin
        bht_r[bp_idx_s] <= bht_step(bht_r[bp_idx_s], bp_taken);
      end
    end
  end

endmodule
